// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: job request, sprite ROM read port and frame-buffer write port.
// master drives requests, ROM data and fb_ready; slave is the blitter.
interface sprite_blitter_if #(
    parameter int ADDR_W    = 9,
    parameter int FB_ADDR_W = 19
);
    logic                 start;
    logic [10:0]          sprite_x;
    logic [10:0]          sprite_y;
    logic                 flip_h;
    logic [ADDR_W-1:0]    rom_addr;
    logic [11:0]          rom_color;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [11:0]          fb_data;
    logic                 fb_ready;
    logic                 busy;
    logic                 done;

    modport master (
        output start, sprite_x, sprite_y, flip_h,
        output rom_color, fb_ready,
        input  rom_addr, fb_we, fb_addr, fb_data,
        input  busy, done
    );

    modport slave (
        input  start, sprite_x, sprite_y, flip_h,
        input  rom_color, fb_ready,
        output rom_addr, fb_we, fb_addr, fb_data,
        output busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies a 20x22 sprite ROM into the frame buffer at a signed screen
// position, skipping key-colour pixels and clipping off-screen ones.
module sprite_blitter #(
    parameter int          SPR_W     = 20,
    parameter int          SPR_H     = 22,
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter logic [11:0] KEY_COLOR = 12'h808,
    parameter int          ADDR_W    = 9,
    parameter int          FB_ADDR_W = 19
) (
    input logic              Clk,
    input logic              Reset_n,
    sprite_blitter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [4:0]        COL_LAST = 5'(SPR_W - 1);
    localparam logic [4:0]        ROW_LAST = 5'(SPR_H - 1);
    localparam logic signed [11:0] SW     = 12'(SCREEN_W);
    localparam logic signed [11:0] SH     = 12'(SCREEN_H);

    state_e state_q, state_d;

    logic signed [10:0]   x_q, x_d;
    logic signed [10:0]   y_q, y_d;
    logic                 flip_q, flip_d;
    logic [4:0]           col_q, col_d;
    logic [4:0]           row_q, row_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [11:0]          fb_data_q, fb_data_d;

    logic signed [11:0]   px, py;
    logic                 on_screen;
    logic                 draw;
    logic                 last_px;
    logic                 advance;
    logic [4:0]           col_nx, row_nx;
    logic [FB_ADDR_W-1:0] pix_addr;

    // ROM address of sprite pixel (r, c), mirrored horizontally when f
    function automatic logic [ADDR_W-1:0] spr_addr(
        input logic [4:0] r,
        input logic [4:0] c,
        input logic       f
    );
        logic [4:0] cc;
        cc = f ? (COL_LAST - c) : c;
        return ADDR_W'(r) * ADDR_W'(SPR_W) + ADDR_W'(cc);
    endfunction

    assign px = $signed({x_q[10], x_q}) + $signed({7'b0, col_q});
    assign py = $signed({y_q[10], y_q}) + $signed({7'b0, row_q});

    assign on_screen = (px >= 12'sd0) && (px < SW) &&
                       (py >= 12'sd0) && (py < SH);
    assign draw      = (bus.rom_color != KEY_COLOR) && on_screen;
    assign last_px   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign advance   = ((state_q == READ) && !draw) ||
                       ((state_q == WRITE) && bus.fb_ready);

    assign col_nx = (col_q == COL_LAST) ? 5'd0 : col_q + 5'd1;
    assign row_nx = (col_q == COL_LAST) ? row_q + 5'd1 : row_q;

    assign pix_addr = FB_ADDR_W'(py[8:0]) * FB_ADDR_W'(SCREEN_W) +
                      FB_ADDR_W'(px[9:0]);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = READ;
            end
            READ: begin
                if (draw)         state_d = WRITE;
                else if (last_px) state_d = DONE;
                else              state_d = READ;
            end
            WRITE: begin
                if (bus.fb_ready) state_d = last_px ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.fb_we = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        unique case (state_q)
            READ: begin
                bus.busy = 1'b1;
            end
            WRITE: begin
                bus.busy  = 1'b1;
                bus.fb_we = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        flip_d     = flip_q;
        col_d      = col_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        if ((state_q == IDLE) && bus.start) begin
            x_d        = bus.sprite_x;
            y_d        = bus.sprite_y;
            flip_d     = bus.flip_h;
            col_d      = 5'd0;
            row_d      = 5'd0;
            rom_addr_d = spr_addr(5'd0, 5'd0, bus.flip_h);
        end
        if ((state_q == READ) && draw) begin
            fb_data_d = bus.rom_color;
            fb_addr_d = pix_addr;
        end
        // the final pixel leaves col/row parked; the next start reloads them
        if (advance && !last_px) begin
            col_d      = col_nx;
            row_d      = row_nx;
            rom_addr_d = spr_addr(row_nx, col_nx, flip_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            flip_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            flip_q     <= flip_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a pixel-loop model queues the
// expected frame-buffer writes and a monitor checks each accepted write.
module tb_sprite_blitter;

    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    sprite_blitter_if #(.ADDR_W(9), .FB_ADDR_W(19)) bus ();

    sprite_blitter dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        exp_q[$];
    logic [11:0] rom_tbl [512];

    int checks   = 0;
    int failures = 0;

    int busy_cnt, done_cnt, wr_cnt, stall_cnt;
    int first_addr, first_data, last_addr;
    int rdy_mode;
    int stalls_left;

    bit          prev_stall;
    logic [18:0] prev_addr;
    logic [11:0] prev_data;

    assign bus.rom_color = rom_tbl[bus.rom_addr];

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_rom(input int mode);
        for (int i = 0; i < 512; i++) begin
            case (mode)
                0: rom_tbl[i] = 12'hF30;
                1: rom_tbl[i] = (i % 2 == 0) ? 12'h808 : 12'h27B;
                2: rom_tbl[i] = 12'(i);
                default: rom_tbl[i] = ($urandom % 3 == 0) ? 12'h808
                                                          : 12'($urandom);
            endcase
        end
    endtask

    // Reference: visit pixels row-major; keep opaque, on-screen ones
    task automatic model(input int x, input int y, input bit flip);
        int a, px, py;
        exp_q.delete();
        for (int r = 0; r < 22; r++) begin
            for (int c = 0; c < 20; c++) begin
                a  = r * 20 + (flip ? 19 - c : c);
                px = x + c;
                py = y + r;
                if (rom_tbl[a] != 12'h808 && px >= 0 && px < 640 &&
                    py >= 0 && py < 480)
                    exp_q.push_back('{py * 640 + px, int'(rom_tbl[a])});
            end
        end
    endtask

    always @(posedge Clk) begin
        #1;
        case (rdy_mode)
            0: bus.fb_ready = 1'b1;
            1: bus.fb_ready = ($urandom % 3) != 0;
            default: begin
                if (bus.fb_we && stalls_left > 0) begin
                    bus.fb_ready = 1'b0;
                    stalls_left--;
                end else begin
                    bus.fb_ready = 1'b1;
                end
            end
        endcase
    end

    always @(negedge Clk) begin
        wr_t e;
        if (!Reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                chk(bus.busy == 1'b0, "busy_in_done", bus.busy, 0);
            end
            if (prev_stall) begin
                chk(bus.fb_we == 1'b1, "hold_we", bus.fb_we, 1);
                chk(bus.fb_addr == prev_addr, "hold_addr",
                    bus.fb_addr, prev_addr);
                chk(bus.fb_data == prev_data, "hold_data",
                    bus.fb_data, prev_data);
            end
            prev_stall = (bus.fb_we === 1'b1) && !bus.fb_ready;
            prev_addr  = bus.fb_addr;
            prev_data  = bus.fb_data;
            if (prev_stall) stall_cnt++;
            if (bus.fb_we === 1'b1 && bus.fb_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_write", bus.fb_addr, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(bus.fb_addr == e.addr, "wr_addr", bus.fb_addr, e.addr);
                    chk(bus.fb_data == e.data, "wr_data", bus.fb_data, e.data);
                    if (wr_cnt == 0) begin
                        first_addr = int'(bus.fb_addr);
                        first_data = int'(bus.fb_data);
                    end
                    last_addr = int'(bus.fb_addr);
                end
                wr_cnt++;
            end
        end
    end

    task automatic run_job(input int x, input int y, input bit flip,
                           input int mode, input int mid_pulse,
                           input bit done_start);
        bit done_seen;
        int n_exp;
        model(x, y, flip);
        n_exp = exp_q.size();
        rdy_mode   = mode;
        busy_cnt   = 0;
        done_cnt   = 0;
        wr_cnt     = 0;
        stall_cnt  = 0;
        first_addr = -1;
        first_data = -1;
        last_addr  = -1;
        @(posedge Clk);
        #1;
        bus.start    = 1'b1;
        bus.sprite_x = 11'(x);
        bus.sprite_y = 11'(y);
        bus.flip_h   = flip;
        done_seen    = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            @(posedge Clk);
            #1;
            bus.start = 1'b0;
            if (cyc == mid_pulse) begin
                bus.start    = 1'b1;
                bus.sprite_x = 11'($urandom);
                bus.flip_h   = ~flip;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                if (done_start) bus.start = 1'b1;
            end
        end
        chk(done_seen, "done_timeout", done_seen, 1);
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk(bus.busy == 1'b0, "idle_after", bus.busy, 0);
        chk(wr_cnt == n_exp, "write_count", wr_cnt, n_exp);
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        chk(done_cnt == 1, "done_pulses", done_cnt, 1);
        chk(busy_cnt == 440 + n_exp + stall_cnt, "busy_cycles",
            busy_cnt, 440 + n_exp + stall_cnt);
    endtask

    initial begin
        Reset_n      = 1'b0;
        bus.start    = 1'b1;
        bus.sprite_x = '0;
        bus.sprite_y = '0;
        bus.flip_h   = 1'b0;
        bus.fb_ready = 1'b1;
        rdy_mode     = 0;
        stalls_left  = 0;
        prev_stall   = 1'b0;
        wr_cnt       = 0;
        fill_rom(0);

        repeat (2) @(posedge Clk);
        #1;
        chk(bus.rom_addr == 0, "rst_rom_addr", bus.rom_addr, 0);
        chk(bus.fb_we == 0, "rst_fb_we", bus.fb_we, 0);
        chk(bus.fb_addr == 0, "rst_fb_addr", bus.fb_addr, 0);
        chk(bus.fb_data == 0, "rst_fb_data", bus.fb_data, 0);
        chk(bus.busy == 0, "rst_busy", bus.busy, 0);
        chk(bus.done == 0, "rst_done", bus.done, 0);
        Reset_n   = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk(bus.busy == 0 && bus.fb_we == 0, "post_rst_idle", bus.busy, 0);

        fill_rom(0);
        run_job(100, 50, 1'b0, 0, -1, 1'b0);
        chk(wr_cnt == 440, "t2_writes", wr_cnt, 440);
        chk(busy_cnt == 880, "t2_busy", busy_cnt, 880);
        chk(first_addr == 32100, "t2_first", first_addr, 32100);
        chk(last_addr == 45559, "t2_last", last_addr, 45559);

        fill_rom(1);
        run_job(0, 0, 1'b0, 0, -1, 1'b0);
        chk(wr_cnt == 220, "t3_writes", wr_cnt, 220);
        chk(busy_cnt == 660, "t3_busy", busy_cnt, 660);

        fill_rom(0);
        run_job(630, 0, 1'b0, 0, -1, 1'b0);
        chk(wr_cnt == 220, "t4_right", wr_cnt, 220);
        run_job(-5, 0, 1'b0, 0, -1, 1'b0);
        chk(wr_cnt == 330, "t4_left", wr_cnt, 330);
        run_job(0, 470, 1'b0, 0, -1, 1'b0);
        chk(wr_cnt == 200, "t4_bottom", wr_cnt, 200);

        stalls_left = 3;
        run_job(200, 200, 1'b0, 2, -1, 1'b0);
        chk(wr_cnt == 440, "t5_writes", wr_cnt, 440);
        chk(stall_cnt == 3, "t5_stalls", stall_cnt, 3);

        fill_rom(2);
        run_job(300, 100, 1'b1, 0, 150, 1'b1);
        chk(first_data == 19, "t6_first_data", first_data, 19);
        chk(first_addr == 64300, "t6_first_addr", first_addr, 64300);

        fill_rom(3);
        rdy_mode = 1;
        model(40, 40, 1'b0);
        @(posedge Clk);
        #1;
        bus.start    = 1'b1;
        bus.sprite_x = 11'd40;
        bus.sprite_y = 11'd40;
        bus.flip_h   = 1'b0;
        @(posedge Clk);
        #1;
        bus.start = 1'b0;
        repeat (200) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        chk(bus.fb_we == 0, "abort_we", bus.fb_we, 0);
        chk(bus.busy == 0, "abort_busy", bus.busy, 0);
        Reset_n = 1'b1;
        exp_q.delete();
        repeat (5) @(posedge Clk);
        #1;
        chk(bus.busy == 0 && bus.fb_we == 0, "abort_idle", bus.busy, 0);

        for (int j = 0; j < 10; j++) begin
            fill_rom(3);
            run_job(int'($urandom_range(0, 700)) - 40,
                    int'($urandom_range(0, 540)) - 40,
                    1'($urandom), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 300)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
